// File: rtl/pwm_cmd_pkg.sv
// Shared constants and types for the UART-driven PWM duty command controller.
package pwm_cmd_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DUTY_W = 7;
    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;
    localparam logic [BYTE_W-1:0] ACK_BYTE  = 8'h06;
    localparam logic [BYTE_W-1:0] NAK_BYTE  = 8'h15;
    localparam logic [DUTY_W-1:0] MAX_DUTY  = 7'd100;

    typedef enum logic [1:0] {
        OP_WRITE_ONE = 2'b00,
        OP_WRITE_ALL = 2'b01,
        OP_READ      = 2'b10,
        OP_INVALID   = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Captured CMD and DATA bytes of the frame being parsed
    typedef struct packed {
        logic [BYTE_W-1:0] cmd;
        logic [BYTE_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/pwm_cmd_timeout.sv
// Inter-byte gap timer: counts enabled idle clocks, expired once the count hits the limit.
module pwm_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 8000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // Saturates at the limit so expired stays asserted until cleared
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count != LIMIT)) begin
            count_next = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count_next;
            expired <= (count_next == LIMIT);
        end
    end

endmodule

// File: rtl/pwm_cmd_controller.sv
// Parses SYNC/CMD/DATA/CSUM frames from a UART byte stream, writes or reads
// four PWM duty registers and returns a one-byte response.
module pwm_cmd_controller
    import pwm_cmd_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 8_000_000,
    parameter int unsigned TIMEOUT_US = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [27:0] duty_out,
    output logic [3:0]  duty_update
);

    localparam int unsigned TIMEOUT_CYCLES = (CLOCK_FREQ / 1_000_000) * TIMEOUT_US;

    state_t                          state;
    frame_t                          frame_q;
    logic [NUM_CH-1:0][DUTY_W-1:0]   duty_q;

    logic                 waiting;
    logic                 timer_clear;
    logic                 expired;
    logic                 csum_ok;
    logic                 in_range;
    opcode_t              opcode;
    logic [1:0]           ch;
    logic [BYTE_W-1:0]    resp_byte;
    logic [NUM_CH-1:0]    wr_mask;

    assign duty_out    = duty_q;
    assign waiting     = (state == ST_CMD) || (state == ST_DATA) || (state == ST_CSUM);
    assign timer_clear = !waiting || rx_valid;

    pwm_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (waiting),
        .expired (expired)
    );

    // Frame verdict, evaluated against the CSUM byte as it arrives
    always_comb begin
        csum_ok   = ((frame_q.cmd ^ frame_q.data) == rx_data);
        in_range  = (frame_q.data <= {1'b0, MAX_DUTY});
        opcode    = opcode_t'(frame_q.cmd[7:6]);
        ch        = frame_q.cmd[1:0];
        resp_byte = NAK_BYTE;
        wr_mask   = '0;
        if (csum_ok) begin
            case (opcode)
                OP_WRITE_ONE: begin
                    if (in_range) begin
                        resp_byte   = ACK_BYTE;
                        wr_mask[ch] = 1'b1;
                    end
                end
                OP_WRITE_ALL: begin
                    if (in_range) begin
                        resp_byte = ACK_BYTE;
                        wr_mask   = '1;
                    end
                end
                OP_READ:  resp_byte = {1'b0, duty_q[ch]};
                default:  resp_byte = NAK_BYTE;
            endcase
        end
    end

    // Frame FSM with registered response and duty outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            frame_q     <= '0;
            duty_q      <= '0;
            duty_update <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
        end else begin
            duty_update <= '0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (rx_valid) begin
                        frame_q.cmd <= rx_data;
                        state       <= ST_DATA;
                    end else if (expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        frame_q.data <= rx_data;
                        state        <= ST_CSUM;
                    end else if (expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_CSUM: begin
                    if (rx_valid) begin
                        state       <= ST_RESP;
                        tx_valid    <= 1'b1;
                        tx_data     <= resp_byte;
                        duty_update <= wr_mask;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (wr_mask[i]) begin
                                duty_q[i] <= frame_q.data[DUTY_W-1:0];
                            end
                        end
                    end else if (expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_cmd_controller.sv
// Directed-vector bench for pwm_cmd_controller with hand-computed expectations.
module tb_pwm_cmd_controller;

    localparam int unsigned TIMEOUT_CYCLES = 8000;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [27:0] duty_out;
    logic [3:0]  duty_update;

    logic [27:0] exp_duty;
    int          vectors;
    int          miscompares;

    pwm_cmd_controller #(
        .CLOCK_FREQ (8_000_000),
        .TIMEOUT_US (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .duty_out    (duty_out),
        .duty_update (duty_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] set_ch(input logic [27:0] d, input int ch, input logic [6:0] v);
        logic [27:0] r;
        r = d;
        r[7*ch +: 7] = v;
        return r;
    endfunction

    // Called at a negedge; the byte is sampled on the following posedge
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    // First RESP cycle: response, duty pulse and duty value, then handshake
    task automatic expect_resp(input string tag, input logic [7:0] exp_tx, input logic [3:0] exp_upd);
        check({tag, "_txv"}, 32'(tx_valid), 32'd1);
        check({tag, "_txd"}, 32'(tx_data), 32'(exp_tx));
        check({tag, "_upd"}, 32'(duty_update), 32'(exp_upd));
        check({tag, "_duty"}, 32'(duty_out), 32'(exp_duty));
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check({tag, "_done"}, {27'd0, tx_valid, duty_update}, 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_txv"}, 32'(tx_valid), 32'd0);
            check({tag, "_duty"}, {duty_update, duty_out}, {4'd0, exp_duty});
            @(negedge clk);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        tx_ready    = 1'b0;
        exp_duty    = '0;

        repeat (3) @(negedge clk);
        check("rst_txv", 32'(tx_valid), 32'd0);
        check("rst_txd", 32'(tx_data), 32'd0);
        check("rst_duty", {duty_update, duty_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Non-sync bytes in IDLE are discarded
        send_byte(8'h3C);
        send_byte(8'h00);
        expect_quiet("junk", 2);

        // Write channel 2 = 50
        send_frame(8'hA5, 8'h02, 8'h32, 8'h30);
        exp_duty = set_ch(exp_duty, 2, 7'd50);
        expect_resp("wr2", 8'h06, 4'b0100);

        // Write all = 75, read channel 1 back
        send_frame(8'hA5, 8'h40, 8'h4B, 8'h0B);
        exp_duty = {4{7'd75}};
        expect_resp("wrall", 8'h06, 4'b1111);
        send_frame(8'hA5, 8'h81, 8'h00, 8'h81);
        expect_resp("rd1", 8'h4B, 4'b0000);

        // Error frames: duty 101, bad checksum, invalid opcode
        send_frame(8'hA5, 8'h00, 8'h65, 8'h65);
        expect_resp("nak101", 8'h15, 4'b0000);
        send_frame(8'hA5, 8'h01, 8'h10, 8'h00);
        expect_resp("nakcsum", 8'h15, 4'b0000);
        send_frame(8'hA5, 8'hC0, 8'h00, 8'hC0);
        expect_resp("nakop", 8'h15, 4'b0000);

        // Duty of exactly 100 is accepted
        send_frame(8'hA5, 8'h00, 8'h64, 8'h64);
        exp_duty = set_ch(exp_duty, 0, 7'd100);
        expect_resp("wr100", 8'h06, 4'b0001);

        // Full gap plus the expiring edge: partial frame dropped, trailing bytes ignored
        send_byte(8'hA5);
        send_byte(8'h03);
        repeat (TIMEOUT_CYCLES + 1) @(negedge clk);
        send_byte(8'h10);
        send_byte(8'h0A);
        send_byte(8'h03);
        expect_quiet("tmo", 4);
        send_frame(8'hA5, 8'h03, 8'h10, 8'h13);
        exp_duty = set_ch(exp_duty, 3, 7'd16);
        expect_resp("wr3", 8'h06, 4'b1000);

        // Byte arriving on the cycle the counter reaches the limit still counts
        send_byte(8'hA5);
        send_byte(8'h00);
        repeat (TIMEOUT_CYCLES) @(negedge clk);
        send_byte(8'h32);
        send_byte(8'h32);
        exp_duty = set_ch(exp_duty, 0, 7'd50);
        expect_resp("edge", 8'h06, 4'b0001);

        // Backpressure: response held, injected bytes dropped
        send_frame(8'hA5, 8'h82, 8'h00, 8'h82);
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h4B});
            rx_valid = 1'b0;
            rx_data  = 8'h00;
            if (i == 2) begin rx_valid = 1'b1; rx_data = 8'hA5; end
            if (i == 3) begin rx_valid = 1'b1; rx_data = 8'h00; end
            if (i == 4) begin rx_valid = 1'b1; rx_data = 8'h32; end
            if (i == 5) begin rx_valid = 1'b1; rx_data = 8'h32; end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check("bp_end", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h4B});
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("bp_done", 32'(tx_valid), 32'd0);
        expect_quiet("bp_quiet", 3);
        send_frame(8'hA5, 8'h01, 8'h05, 8'h04);
        exp_duty = set_ch(exp_duty, 1, 7'd5);
        expect_resp("wr1", 8'h06, 4'b0010);

        // Reset while a response is pending
        send_frame(8'hA5, 8'h00, 8'h0A, 8'h0A);
        check("rresp_txv", 32'(tx_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_duty = '0;
        check("rresp_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        check("rresp_duty", {duty_update, duty_out}, 32'd0);

        // Reset mid-frame: the rest of the frame is treated as junk
        send_byte(8'hA5);
        send_byte(8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h32);
        send_byte(8'h32);
        expect_quiet("rmid", 3);
        send_frame(8'hA5, 8'h00, 8'h32, 8'h32);
        exp_duty = set_ch(exp_duty, 0, 7'd50);
        expect_resp("post_rst", 8'h06, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_cmd_controller.md
PWM_CMD_CONTROLLER -- requirements
Module: pwm_cmd_controller

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 8_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 1000, meaning maximum inter-byte gap in microseconds before a partial frame is discarded.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain only.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  received UART byte.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-007 SHALL have port tx_data  output  8  response byte to UART transmitter.
REQ-008 SHALL have port tx_valid  output  1  response byte offered; held until accepted.
REQ-009 SHALL have port tx_ready  input  1  transmitter accepts tx_data when high with tx_valid.
REQ-010 SHALL have port duty_out  output  28  four 7-bit duty values in percent; channel n occupies bits [7n+6:7n].
REQ-011 SHALL have port duty_update  output  4  one-cycle pulse per channel whose duty was written.

Function
REQ-012 SHALL parse fixed 4-byte frames: SYNC (0xA5), CMD, DATA, CSUM.
REQ-013 CMD bits [7:6] SHALL be the opcode: 00 write channel CMD[1:0], 01 write all channels, 10 read channel CMD[1:0], 11 invalid. CMD[5:2] SHALL be ignored.
REQ-014 CSUM SHALL equal CMD XOR DATA; a mismatch makes the frame an error.
REQ-015 The FSM SHALL have states IDLE, CMD, DATA, CSUM, RESP.
REQ-016 IDLE -> CMD on rx_valid with 0xA5; other bytes in IDLE SHALL be discarded silently.
REQ-017 CMD -> DATA -> CSUM SHALL advance one state per rx_valid; CSUM byte received -> RESP.
REQ-018 Frame evaluation on entering RESP:
- bad CSUM, opcode 11, or write with DATA > 100: tx_data = 0x15 (NAK), no duty change.
- valid write: tx_data = 0x06 (ACK).
- valid read: tx_data = current duty of the channel, zero-extended; DATA is ignored except for CSUM.
REQ-019 A valid write SHALL update duty_out and pulse the matching duty_update bit(s) in the same cycle the RESP state is entered. This is one cycle after the CSUM strobe.
REQ-020 Opcode 01 SHALL write all four channels simultaneously and pulse duty_update = 4'b1111.
REQ-021 tx_valid SHALL assert on the first cycle in RESP. tx_data and tx_valid SHALL then be held stable until the cycle with tx_valid and tx_ready; that cycle SHALL return the FSM to IDLE.
REQ-022 rx_valid strobes arriving in RESP SHALL be dropped; they SHALL NOT start a new frame.
REQ-023 In CMD, DATA and CSUM, a gap of TIMEOUT_CYCLES = (CLOCK_FREQ/1_000_000)*TIMEOUT_US clocks without rx_valid SHALL return the FSM to IDLE. This produces no response and no duty change; the default is 8000 cycles.
REQ-024 The timeout counter SHALL clear on every accepted rx_valid and in IDLE/RESP. Its width SHALL be $clog2(TIMEOUT_CYCLES+1).
REQ-025 A rx_valid in the same cycle the counter reaches TIMEOUT_CYCLES SHALL be accepted; the byte wins and there is no timeout.
REQ-026 A 0xA5 byte in CMD, DATA or CSUM SHALL be treated as frame data, not as a resync.
REQ-027 duty_out SHALL change only on a valid write; duty_update SHALL be 0 in all other cycles.

Reset
REQ-028 When rst is high at a clk edge, the block SHALL go to state IDLE, with duty_out = 0, duty_update = 0, tx_valid = 0, tx_data = 0x00 and the timeout counter = 0.
REQ-029 Reset mid-frame or in RESP SHALL abandon the frame with no response and no duty change.

Structure
REQ-030 The constants SYNC 0xA5, ACK 0x06, NAK 0x15, the opcode encodings, the state encodings and the max duty of 100 SHALL live in shared package pwm_cmd_pkg.
REQ-031 The inter-byte timer SHALL be a sub-module named pwm_cmd_timeout, with ports clk, rst, clear, enable and expired.
REQ-032 duty_out SHALL feed a PWM generator's duty registers directly; no other datapath SHALL be in this block.

Verification
REQ-033 Write: frame A5 02 32 30 -> ACK 0x06; duty_out channel 2 = 50; duty_update = 4'b0100 for one cycle.
REQ-034 Write all, then read back: frame A5 40 4B 0B -> ACK, all channels = 75, duty_update = 4'b1111. Then frame A5 81 00 81 -> tx_data = 0x4B.
REQ-035 Errors: frames A5 00 65 65 (duty 101), A5 01 10 00 (bad CSUM) and A5 C0 00 C0 (opcode 11) -> each returns NAK 0x15, duty_out unchanged, duty_update = 0.
REQ-036 Timeout: send A5 03, idle 8000 cycles, then 10 0A 03 -> no response. Resending A5 03 10 13 -> ACK, channel 3 = 16.
REQ-037 Backpressure and reset:
- Hold tx_ready = 0 for 20 cycles after a CSUM byte -> tx_data and tx_valid are stable, and injected rx bytes are dropped.
- Assert rst mid-frame -> all outputs return to reset values.
